series_host: RTL and testbench
==============================

// Module: series_host
// PURPOSE
//  Initiator side of the series-engine start/compute handshake; the engine controller is the responder.
//  - Accepts one operand x from an upstream valid/ready stream.
//  - Presents x to the engine and holds eng_start high for START_HOLD cycles, which covers the engine's load phase.
//  - Waits for the engine's completion pulse, captures the result and returns it on a downstream valid/ready stream.
//  - Sits between the system datapath and the series engine; at most one job in flight.
// PARAMETERS
//  DATA_W      16   operand/result width
//  START_HOLD  2    cycles eng_start stays high per job; range 1..15
//  TIMEOUT     255  max WAIT cycles before abort; used only with SERIES_HOST_TIMEOUT_EN; range 1..65535
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  in_valid    in   1       upstream operand valid
//  in_ready    out  1       host can accept an operand
//  in_x        in   DATA_W  operand
//  eng_start   out  1       start request to engine (level, held START_HOLD cycles)
//  eng_x       out  DATA_W  operand to engine; stable from accept until return to IDLE
//  eng_done    in   1       engine result-valid pulse
//  eng_result  in   DATA_W  engine result; qualified by eng_done
//  out_valid   out  1       result valid
//  out_ready   in   1       downstream accepts result
//  out_y       out  DATA_W  result
//  out_err     out  1       result aborted by timeout; qualified by out_valid
//  busy        out  1       host is not in IDLE
// BEHAVIOUR
//  Reset (async, rst=1)
//  - state=IDLE; eng_start, out_valid, out_err, busy = 0; eng_x, out_y, all counters = 0.
//  - eng_start drops immediately, without waiting for a clock edge.
//  - In-flight job is discarded. An eng_done arriving after reset is ignored because state is IDLE.
//  States: IDLE -> START -> WAIT -> RESP -> IDLE
//  - IDLE
//    - in_ready=1.
//    - On in_valid&in_ready at edge N: latch in_x into eng_x, clear hold_cnt, move to START.
//  - START
//    - eng_start=1 for exactly START_HOLD cycles, N+1 .. N+START_HOLD.
//    - hold_cnt counts up; at hold_cnt==START_HOLD-1, move to WAIT.
//    - eng_done is ignored in START.
//  - WAIT
//    - eng_start=0; wait_cnt increments each cycle.
//    - eng_done=1 at edge M: out_y<=eng_result, out_err<=0, move to RESP. out_valid is 1 from cycle M+1.
//  - RESP
//    - out_valid=1; out_y and out_err are held stable until the handshake.
//    - out_valid&out_ready: move to IDLE. in_ready is 1 in the next cycle; there is no same-cycle re-accept.
//  - Handshake rules
//    - in_ready is 0 in START, WAIT and RESP.
//    - out_valid never drops without out_ready.
//    - eng_done in IDLE or RESP: ignored, no state change, no counter change.
//  - Latency
//    - Accept to first eng_start cycle: 1.
//    - eng_done to out_valid: 1.
//    - Minimum accept to out_valid: START_HOLD+2 cycles, with eng_done in the first WAIT cycle.
//  - Width and wrap
//    - hold_cnt is 4 bits; wait_cnt is 16 bits and saturates at all-ones (no wrap).
//    - Data passes through unmodified; no arithmetic on data.
//  - busy = (state != IDLE).
// CONFIGURATION
//  SERIES_HOST_TIMEOUT_EN defined:
//  - In WAIT, if wait_cnt reaches TIMEOUT-1 with no eng_done: move to RESP with out_y=0, out_err=1.
//  - eng_done in that same cycle wins: normal result, out_err=0.
//  SERIES_HOST_TIMEOUT_EN undefined:
//  - WAIT lasts until eng_done or reset; out_err is tied 0; TIMEOUT is unused.
// TESTING
//  1. in_x=16'h0040, in_valid pulse, START_HOLD=2, eng_done at 5th WAIT cycle with eng_result=16'h1234
//     -> eng_start high exactly 2 cycles; out_valid next cycle; out_y=16'h1234; out_err=0.
//  2. out_ready held low 10 cycles after out_valid
//     -> out_valid and out_y stable for all 10 cycles; in_ready=0 throughout; IDLE one cycle after out_ready=1.
//  3. eng_done pulses during START and in IDLE
//     -> ignored; still WAIT / IDLE; out_valid stays 0.
//  4. rst asserted mid-WAIT, between clock edges
//     -> eng_start, out_valid, busy = 0 immediately; a later eng_done produces no output; next job completes normally.
//  5. SERIES_HOST_TIMEOUT_EN, TIMEOUT=8, no eng_done
//     -> out_valid after 8 WAIT cycles, out_y=0, out_err=1. Repeat with eng_done on the 8th cycle -> out_err=0, real result.
//  6. Back-to-back: in_valid held high, out_ready held high, 3 operands
//     -> 3 results in order; each accept exactly 1 cycle after the previous out handshake.

Source files
------------

// File: rtl/series_host.sv
// series_host: initiator side of the series-engine start/compute handshake.
// Takes one operand from an upstream valid/ready stream and presents it to
// the engine. It holds eng_start for START_HOLD cycles, waits for eng_done,
// and returns the captured result on a downstream valid/ready stream.
// At most one job is in flight at a time.
// Optional feature macro: SERIES_HOST_TIMEOUT_EN. When it is defined, a WAIT
// phase lasting TIMEOUT cycles aborts the job with out_y=0 and out_err=1.
module series_host #(
  parameter int DATA_W     = 16,
  parameter int START_HOLD = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_x,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic              out_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last hold_cnt value of the START phase, and last wait_cnt value before abort.
  localparam logic [3:0]  HOLD_LAST = 4'(START_HOLD - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        hold_cnt;
  logic [15:0]       wait_cnt;
  logic [DATA_W-1:0] eng_x_r;
  logic [DATA_W-1:0] out_y_r;
  logic              out_err_r;
  logic              accept;
  logic              wait_expire;

  // wait_cnt counts WAIT cycles and sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  assign accept = (state == S_IDLE) && in_valid;

`ifdef SERIES_HOST_TIMEOUT_EN
  assign wait_expire = (state == S_WAIT) && (wait_cnt == WAIT_LAST);
`else
  // WAIT only ends on eng_done or reset. The counter is still kept, and this
  // sink swallows the otherwise unread timeout terms.
  logic unused_timeout;
  assign wait_expire    = 1'b0;
  assign unused_timeout = ^{wait_cnt, WAIT_LAST};
`endif

  // State register; reset discards any in-flight job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus the handshake outputs, decoded purely from state
  // so that an asynchronous reset drops them at once.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    eng_start = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_START;
      end
      S_START: begin
        eng_start = 1'b1;
        if (hold_cnt == HOLD_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done || wait_expire) state_nxt = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, result capture and phase counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_x_r   <= '0;
      out_y_r   <= '0;
      out_err_r <= 1'b0;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      if (accept) begin
        eng_x_r  <= in_x;
        hold_cnt <= '0;
        wait_cnt <= '0;
      end
      if (state == S_START) hold_cnt <= hold_cnt + 4'd1;
      if (state == S_WAIT) begin
        wait_cnt <= sat_inc16(wait_cnt);
        // A completion in the expiry cycle still delivers the real result.
        if (eng_done) begin
          out_y_r   <= eng_result;
          out_err_r <= 1'b0;
        end else if (wait_expire) begin
          out_y_r   <= '0;
          out_err_r <= 1'b1;
        end
      end
    end
  end

  assign eng_x   = eng_x_r;
  assign out_y   = out_y_r;
  assign out_err = out_err_r;

endmodule

// File: tb/tb_series_host.sv
// Self-checking bench for series_host: a scoreboard queue holds the expected
// results, which are pushed when an operand is offered and popped when the
// host returns a result.
module tb_series_host;

  localparam int DATA_W     = 16;
  localparam int START_HOLD = 2;
  localparam int TIMEOUT    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic              eng_start;
  logic [DATA_W-1:0] eng_x;
  logic              eng_done;
  logic [DATA_W-1:0] eng_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic              out_err;
  logic              busy;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  series_host #(
    .DATA_W    (DATA_W),
    .START_HOLD(START_HOLD),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_done  (eng_done),
    .eng_result(eng_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference engine transfer function used by the bench only.
  function automatic logic [DATA_W-1:0] eng_model(input logic [DATA_W-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Waits (bounded) for out_valid, stalls the sink for ready_delay cycles
  // while checking stability, then completes the handshake and compares.
  task automatic collect(input int ready_delay);
    exp_t e;
    int   n;
    chk("resp_latency", out_valid, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) begin
      chk("resp_timeout", 0, 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < ready_delay; i++) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_y", out_y, e.y);
      chk("hold_in_ready", in_ready, 1'b0);
      step();
    end
    chk("out_y", out_y, e.y);
    chk("out_err", out_err, e.err);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 1'b0);
    chk("post_hs_in_ready", in_ready, 1'b1);
    chk("post_hs_busy", busy, 1'b0);
  endtask

  // One job driven cycle by cycle from IDLE. done_at is the 1-based WAIT
  // cycle carrying eng_done; 0 means never, which relies on the timeout.
  task automatic run_job(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] res,
                         input int done_at, input bit noise_in_start, input int ready_delay);
    exp_t e;
    int   wait_len;
    chk("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_x     = x;
    if (done_at > 0) e = '{y: res, err: 1'b0};
    else             e = '{y: '0, err: 1'b1};
    sb_q.push_back(e);
    step();
    in_valid = 1'b0;
    in_x     = '0;
    for (int i = 0; i < START_HOLD; i++) begin
      chk("start_level", eng_start, 1'b1);
      chk("start_in_ready", in_ready, 1'b0);
      chk("start_eng_x", eng_x, x);
      if (noise_in_start && i == 0) begin
        eng_done   = 1'b1;
        eng_result = 16'hDEAD;
      end
      step();
      eng_done   = 1'b0;
      eng_result = '0;
    end
    wait_len = (done_at > 0) ? done_at : TIMEOUT;
    for (int k = 1; k <= wait_len; k++) begin
      chk("wait_no_start", eng_start, 1'b0);
      chk("wait_no_valid", out_valid, 1'b0);
      chk("wait_busy", busy, 1'b1);
      chk("wait_eng_x", eng_x, x);
      if (k == done_at) begin
        eng_done   = 1'b1;
        eng_result = res;
      end
      step();
      eng_done   = 1'b0;
      eng_result = '0;
    end
    collect(ready_delay);
  endtask

  initial begin
    exp_t             e;
    logic [DATA_W-1:0] ops [3];
    int               acc_n;
    int               hs_n;
    int               last_hs;
    bit               prev_start;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_x       = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    out_ready  = 1'b0;
    #1;
    chk("rst_eng_start", eng_start, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_eng_x", eng_x, 16'h0000);
    chk("rst_out_y", out_y, 16'h0000);
    step();
    step();
    rst = 1'b0;
    chk("idle_ready_after_rst", in_ready, 1'b1);

    // Basic job, completion on the 5th WAIT cycle.
    run_job(16'h0040, 16'h1234, 5, 1'b0, 0);

    // Minimum latency with a sink stalled for 10 cycles.
    run_job(16'h0041, 16'h5678, 1, 1'b0, 10);

    // eng_done while IDLE is ignored.
    eng_done   = 1'b1;
    eng_result = 16'hBEEF;
    step();
    eng_done   = 1'b0;
    eng_result = '0;
    chk("idle_done_valid", out_valid, 1'b0);
    chk("idle_done_busy", busy, 1'b0);
    step();
    chk("idle_done_valid2", out_valid, 1'b0);

    // eng_done while in START is ignored; the job still completes later.
    run_job(16'h0042, 16'h9ABC, 3, 1'b1, 2);

    // Asynchronous reset while in START drops eng_start without an edge.
    in_valid = 1'b1;
    in_x     = 16'h0777;
    step();
    in_valid = 1'b0;
    chk("pre_rst_start", eng_start, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_start", eng_start, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_eng_x", eng_x, 16'h0000);
    step();
    rst = 1'b0;

    // Asynchronous reset mid-WAIT, then a stale eng_done.
    in_valid = 1'b1;
    in_x     = 16'h0888;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < START_HOLD + 2; i++) step();
    chk("pre_rst_wait_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("wait_rst_start", eng_start, 1'b0);
    chk("wait_rst_valid", out_valid, 1'b0);
    chk("wait_rst_busy", busy, 1'b0);
    step();
    rst        = 1'b0;
    eng_done   = 1'b1;
    eng_result = 16'hBADD;
    step();
    eng_done   = 1'b0;
    eng_result = '0;
    for (int i = 0; i < 3; i++) begin
      chk("stale_done_valid", out_valid, 1'b0);
      chk("stale_done_busy", busy, 1'b0);
      step();
    end
    run_job(16'h0999, 16'h0F0F, 2, 1'b0, 1);

`ifdef SERIES_HOST_TIMEOUT_EN
    // No completion: aborts after TIMEOUT WAIT cycles.
    run_job(16'h0AAA, 16'h0000, 0, 1'b0, 0);
    // Completion in the expiry cycle wins.
    run_job(16'h0BBB, 16'h4321, TIMEOUT, 1'b0, 0);
`endif

    // Back-to-back: source and sink always ready, engine answers at once.
    ops[0]     = 16'h0101;
    ops[1]     = 16'h0202;
    ops[2]     = 16'hFFFF;
    acc_n      = 0;
    hs_n       = 0;
    last_hs    = -10;
    prev_start = 1'b0;
    in_valid   = 1'b1;
    in_x       = ops[0];
    out_ready  = 1'b1;
    for (int c = 0; c < 100 && hs_n < 3; c++) begin
      eng_done   = prev_start && !eng_start && busy;
      eng_result = eng_model(eng_x);
      prev_start = eng_start;
      if (in_valid && in_ready) begin
        sb_q.push_back('{y: eng_model(ops[acc_n]), err: 1'b0});
        if (acc_n > 0) chk("b2b_accept_gap", c - last_hs, 1);
        acc_n++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("b2b_sb_empty", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk("b2b_out_y", out_y, e.y);
          chk("b2b_out_err", out_err, e.err);
        end
        last_hs = c;
        hs_n++;
      end
      step();
      if (acc_n < 3) in_x = ops[acc_n];
      else           in_valid = 1'b0;
    end
    eng_done  = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_count", hs_n, 3);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
